// File: rtl/multi_issue_instruction_queue_if.sv
// Bundle of the enqueue/dequeue signals of multi_issue_instruction_queue.
//   master: fetch/decode + rename/dispatch side (drives enq_*, deq_num)
//   slave : the queue (drives enq_ready, deq_*, count, full, empty)
// Lane i of each packed bus lives at [i*WIDTH +: WIDTH]; lane 0 is oldest.
interface multi_issue_instruction_queue_if #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned META_WIDTH  = 256,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned ENQ_WIDTH   = 2,
  parameter int unsigned DEQ_WIDTH   = 2
);
  logic [$clog2(ENQ_WIDTH+1)-1:0]    enq_num;
  logic [ENQ_WIDTH*DATA_WIDTH-1:0]   enq_data;
  logic [ENQ_WIDTH*META_WIDTH-1:0]   enq_meta;
  logic                              enq_ready;
  logic [DEQ_WIDTH-1:0]              deq_valid;
  logic [DEQ_WIDTH*DATA_WIDTH-1:0]   deq_data;
  logic [DEQ_WIDTH*META_WIDTH-1:0]   deq_meta;
  logic [$clog2(DEQ_WIDTH+1)-1:0]    deq_num;
  logic [$clog2(QUEUE_DEPTH):0]      count;
  logic                              full;
  logic                              empty;

  modport master (
    output enq_num, enq_data, enq_meta, deq_num,
    input  enq_ready, deq_valid, deq_data, deq_meta, count, full, empty
  );

  modport slave (
    input  enq_num, enq_data, enq_meta, deq_num,
    output enq_ready, deq_valid, deq_data, deq_meta, count, full, empty
  );
endinterface

// File: rtl/multi_issue_instruction_queue.sv
// Multi-lane first-word-fall-through instruction queue with per-entry
// sideband metadata.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   flush : discard all entries at the next edge
//   bus   : enqueue (enq_num/enq_data/enq_meta/enq_ready) and dequeue
//           (deq_valid/deq_data/deq_meta/deq_num) lanes plus count/full/empty
// Enqueue is all-or-nothing and gated only by the registered count, so a
// same-cycle pop never frees space for a same-cycle push.
module multi_issue_instruction_queue #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned META_WIDTH  = 256,
  parameter int unsigned QUEUE_DEPTH = 16,
  parameter int unsigned ENQ_WIDTH   = 2,
  parameter int unsigned DEQ_WIDTH   = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  multi_issue_instruction_queue_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q [QUEUE_DEPTH];
  logic [DATA_WIDTH-1:0] data_d [QUEUE_DEPTH];
  logic [META_WIDTH-1:0] meta_q [QUEUE_DEPTH];
  logic [META_WIDTH-1:0] meta_d [QUEUE_DEPTH];

  logic                  enq_ok;
  logic [CNT_W-1:0]      enq_req;
  logic [CNT_W-1:0]      enq_acc;
  logic [CNT_W-1:0]      deq_req;
  logic [CNT_W-1:0]      pop;
  logic [PTR_W-1:0]      wr_idx;
  logic [PTR_W-1:0]      rd_idx;

  // Next-state: clamp both requests, then advance pointers modulo depth
  // (depth is a power of two, so pointer truncation is the wrap).
  always_comb begin
    enq_ok  = (CNT_W'(QUEUE_DEPTH) - count_q) >= CNT_W'(ENQ_WIDTH);
    enq_req = CNT_W'(bus.enq_num);
    if (enq_req > CNT_W'(ENQ_WIDTH)) begin
      enq_req = CNT_W'(ENQ_WIDTH);
    end
    enq_acc = enq_ok ? enq_req : '0;
    deq_req = CNT_W'(bus.deq_num);
    pop     = (deq_req > count_q) ? count_q : deq_req;

    data_d  = data_q;
    meta_d  = meta_q;
    wr_idx  = tail_q;
    head_d  = head_q + PTR_W'(pop);
    tail_d  = tail_q + PTR_W'(enq_acc);
    count_d = count_q + enq_acc - pop;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      for (int unsigned l = 0; l < ENQ_WIDTH; l++) begin
        if (CNT_W'(l) < enq_acc) begin
          wr_idx         = tail_q + PTR_W'(l);
          data_d[wr_idx] = bus.enq_data[l*DATA_WIDTH +: DATA_WIDTH];
          meta_d[wr_idx] = bus.enq_meta[l*META_WIDTH +: META_WIDTH];
        end
      end
    end
  end

  // Outputs depend only on registered head/count, so they follow an
  // asynchronous reset immediately and there is no enqueue bypass.
  always_comb begin
    bus.enq_ready = enq_ok;
    bus.count     = count_q;
    bus.full      = (count_q == CNT_W'(QUEUE_DEPTH));
    bus.empty     = (count_q == '0);
    bus.deq_valid = '0;
    bus.deq_data  = '0;
    bus.deq_meta  = '0;
    rd_idx        = head_q;
    for (int unsigned i = 0; i < DEQ_WIDTH; i++) begin
      if (count_q > CNT_W'(i)) begin
        rd_idx                                   = head_q + PTR_W'(i);
        bus.deq_valid[i]                         = 1'b1;
        bus.deq_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[rd_idx];
        bus.deq_meta[i*META_WIDTH +: META_WIDTH] = meta_q[rd_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never read past count, so it needs no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    meta_q <= meta_d;
  end
endmodule

// File: tb/tb_multi_issue_instruction_queue.sv
// Testbench for multi_issue_instruction_queue (depth 16, 2 enqueue / 2
// dequeue lanes). Reference model is a queue of entries updated per edge.
module tb_multi_issue_instruction_queue;
  localparam int unsigned DW    = 32;
  localparam int unsigned MW    = 256;
  localparam int unsigned DEPTH = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } item_t;

  typedef struct {
    logic [1:0]  enq_num;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  deq_num;
    logic        fl;
    int unsigned exp_cnt;
    logic [1:0]  exp_valid;
    logic [31:0] exp0;
    logic [31:0] exp1;
    logic        exp_ready;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  item_t mq[$];
  int n_cmp = 0;
  int n_bad = 0;

  multi_issue_instruction_queue_if #(
    .DATA_WIDTH(DW), .META_WIDTH(MW), .QUEUE_DEPTH(DEPTH),
    .ENQ_WIDTH(2), .DEQ_WIDTH(2)
  ) bus ();

  multi_issue_instruction_queue #(
    .DATA_WIDTH(DW), .META_WIDTH(MW), .QUEUE_DEPTH(DEPTH),
    .ENQ_WIDTH(2), .DEQ_WIDTH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [MW-1:0] rep(input logic [31:0] d);
    return {8{d}};
  endfunction

  // Model: one edge of the queue, described as list operations.
  task automatic model_step(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                            input logic [1:0] dn, input logic fl);
    int unsigned sz;
    int unsigned np;
    int unsigned ne;
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      np = (int'(dn) > sz) ? sz : int'(dn);
      ne = (en > 2'd2) ? 2 : int'(en);
      if (DEPTH - sz < 2) ne = 0;
      repeat (np) void'(mq.pop_front());
      if (ne >= 1) mq.push_back('{d: d0, m: m0});
      if (ne >= 2) mq.push_back('{d: d1, m: m1});
    end
  endtask

  task automatic cycle(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [MW-1:0] m0, input logic [MW-1:0] m1,
                       input logic [1:0] dn, input logic fl);
    bus.enq_num  = en;
    bus.enq_data = {d1, d0};
    bus.enq_meta = {m1, m0};
    bus.deq_num  = dn;
    flush        = fl;
    @(posedge clk);
    model_step(en, d0, d1, m0, m1, dn, fl);
    #1;
  endtask

  task automatic cyc(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1,
                     input logic [1:0] dn, input logic fl);
    cycle(en, d0, d1, rep(d0), rep(d1), dn, fl);
  endtask

  task automatic idle_inputs();
    bus.enq_num  = '0;
    bus.enq_data = '0;
    bus.enq_meta = '0;
    bus.deq_num  = '0;
    flush        = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    rst_n = 1'b1;
  endtask

  task automatic check_model(input string tag);
    int unsigned sz;
    logic [31:0] ed;
    logic [MW-1:0] em;
    sz = mq.size();
    chk({tag, ".count"}, MW'(bus.count), MW'(sz));
    chk({tag, ".full"}, MW'(bus.full), MW'(sz == DEPTH));
    chk({tag, ".empty"}, MW'(bus.empty), MW'(sz == 0));
    chk({tag, ".enq_ready"}, MW'(bus.enq_ready), MW'(DEPTH - sz >= 2));
    for (int i = 0; i < 2; i++) begin
      ed = (i < int'(sz)) ? mq[i].d : '0;
      em = (i < int'(sz)) ? mq[i].m : '0;
      chk({tag, ".deq_valid"}, MW'(bus.deq_valid[i]), MW'(i < int'(sz)));
      chk({tag, ".deq_data"}, MW'(bus.deq_data[i*DW +: DW]), MW'(ed));
      chk({tag, ".deq_meta"}, bus.deq_meta[i*MW +: MW], em);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".count"}, MW'(bus.count), '0);
    chk({tag, ".empty"}, MW'(bus.empty), MW'(1));
    chk({tag, ".full"}, MW'(bus.full), '0);
    chk({tag, ".enq_ready"}, MW'(bus.enq_ready), MW'(1));
    chk({tag, ".deq_valid"}, MW'(bus.deq_valid), '0);
    chk({tag, ".deq_data"}, MW'(bus.deq_data), '0);
    chk({tag, ".deq_meta"}, bus.deq_meta[MW-1:0] | bus.deq_meta[2*MW-1:MW], '0);
  endtask

  initial begin
    vec_t vecs[8];
    int unsigned nexp;
    int unsigned np;
    int unsigned guard;
    logic [1:0]  ren;
    logic [1:0]  rdn;
    logic        rfl;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [MW-1:0] rm0;
    logic [MW-1:0] rm1;

    vecs[0] = '{2'd2, 32'h11, 32'h22, 2'd0, 1'b0, 2, 2'b11, 32'h11, 32'h22, 1'b1};
    vecs[1] = '{2'd1, 32'h33, 32'h0,  2'd1, 1'b0, 2, 2'b11, 32'h22, 32'h33, 1'b1};
    vecs[2] = '{2'd0, 32'h0,  32'h0,  2'd2, 1'b0, 0, 2'b00, 32'h0,  32'h0,  1'b1};
    vecs[3] = '{2'd3, 32'h44, 32'h55, 2'd2, 1'b0, 2, 2'b11, 32'h44, 32'h55, 1'b1};
    vecs[4] = '{2'd2, 32'h66, 32'h77, 2'd1, 1'b0, 3, 2'b11, 32'h55, 32'h66, 1'b1};
    vecs[5] = '{2'd2, 32'h88, 32'h99, 2'd1, 1'b1, 0, 2'b00, 32'h0,  32'h0,  1'b1};
    vecs[6] = '{2'd1, 32'hAA, 32'h0,  2'd0, 1'b0, 1, 2'b01, 32'hAA, 32'h0,  1'b1};
    vecs[7] = '{2'd0, 32'h0,  32'h0,  2'd2, 1'b0, 0, 2'b00, 32'h0,  32'h0,  1'b1};

    rst_n = 1'b0;
    idle_inputs();
    do_reset();
    check_reset_outputs("reset");

    // Directed table
    for (int v = 0; v < 8; v++) begin
      cyc(vecs[v].enq_num, vecs[v].d0, vecs[v].d1, vecs[v].deq_num, vecs[v].fl);
      chk($sformatf("vec%0d.count", v), MW'(bus.count), MW'(vecs[v].exp_cnt));
      chk($sformatf("vec%0d.deq_valid", v), MW'(bus.deq_valid), MW'(vecs[v].exp_valid));
      chk($sformatf("vec%0d.lane0", v), MW'(bus.deq_data[31:0]), MW'(vecs[v].exp0));
      chk($sformatf("vec%0d.lane1", v), MW'(bus.deq_data[63:32]), MW'(vecs[v].exp1));
      chk($sformatf("vec%0d.meta0", v), bus.deq_meta[MW-1:0], rep(vecs[v].exp0));
      chk($sformatf("vec%0d.enq_ready", v), MW'(bus.enq_ready), MW'(vecs[v].exp_ready));
    end

    // Fill to full, then an ignored ninth offer
    do_reset();
    for (int k = 0; k < 8; k++) cyc(2'd2, 32'(2*k), 32'(2*k+1), 2'd0, 1'b0);
    chk("fill.count", MW'(bus.count), MW'(16));
    chk("fill.full", MW'(bus.full), MW'(1));
    chk("fill.enq_ready", MW'(bus.enq_ready), '0);
    cyc(2'd2, 32'hFF, 32'hFF, 2'd0, 1'b0);
    chk("fill_offer.count", MW'(bus.count), MW'(16));
    chk("fill_offer.lane0", MW'(bus.deq_data[31:0]), MW'(0));
    chk("fill_offer.lane1", MW'(bus.deq_data[63:32]), MW'(1));
    check_model("fill");

    // Count 15: enqueue refused even with a same-cycle pop
    cyc(2'd0, 32'h0, 32'h0, 2'd1, 1'b0);
    chk("c15.count", MW'(bus.count), MW'(15));
    chk("c15.enq_ready", MW'(bus.enq_ready), '0);
    bus.enq_num = 2'd2;
    bus.deq_num = 2'd1;
    #1;
    chk("c15_same_cycle.enq_ready", MW'(bus.enq_ready), '0);
    cyc(2'd2, 32'hEE, 32'hEF, 2'd1, 1'b0);
    chk("c15_after.count", MW'(bus.count), MW'(14));
    chk("c15_after.enq_ready", MW'(bus.enq_ready), MW'(1));
    nexp = 2;
    guard = 0;
    while (mq.size() > 0 && guard < 20) begin
      np = (mq.size() < 2) ? mq.size() : 2;
      for (int j = 0; j < int'(np); j++) begin
        chk("drain.stream", MW'(bus.deq_data[j*DW +: DW]), MW'(nexp));
        nexp++;
      end
      cyc(2'd0, 32'h0, 32'h0, 2'd2, 1'b0);
      guard++;
    end
    chk("drain.last", MW'(nexp), MW'(16));
    check_model("drained");

    // Wrap-around stream: steady enq 2 / deq 2 past the pointer wrap
    do_reset();
    nexp = 0;
    for (int c = 0; c < 14; c++) begin
      np = (mq.size() < 2) ? mq.size() : 2;
      for (int j = 0; j < int'(np); j++) begin
        chk("wrap.stream", MW'(bus.deq_data[j*DW +: DW]), MW'(nexp));
        nexp++;
      end
      cyc(2'd2, 32'(2*c), 32'(2*c+1), 2'd2, 1'b0);
      check_model("wrap");
    end
    chk("wrap.popped", MW'(nexp), MW'(26));

    // Flush at count 5 with a same-cycle enqueue
    do_reset();
    cyc(2'd2, 32'h1, 32'h2, 2'd0, 1'b0);
    cyc(2'd2, 32'h3, 32'h4, 2'd0, 1'b0);
    cyc(2'd1, 32'h5, 32'h0, 2'd0, 1'b0);
    chk("flush_pre.count", MW'(bus.count), MW'(5));
    cyc(2'd2, 32'h6, 32'h7, 2'd1, 1'b1);
    chk("flush.count", MW'(bus.count), '0);
    chk("flush.empty", MW'(bus.empty), MW'(1));
    chk("flush.deq_valid", MW'(bus.deq_valid), '0);

    // Asynchronous reset in the middle of a cycle
    cyc(2'd2, 32'hA1, 32'hA2, 2'd0, 1'b0);
    cyc(2'd2, 32'hA3, 32'hA4, 2'd0, 1'b0);
    chk("async_pre.count", MW'(bus.count), MW'(4));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(posedge clk);
    #1;
    mq.delete();
    idle_inputs();
    rst_n = 1'b1;
    check_model("post_reset");

    // Randomised traffic against the model
    for (int r = 0; r < 600; r++) begin
      ren = 2'($urandom_range(0, 3));
      rdn = 2'($urandom_range(0, 2));
      rfl = ($urandom_range(0, 40) == 0);
      rd0 = $urandom;
      rd1 = $urandom;
      for (int w = 0; w < 8; w++) begin
        rm0[w*32 +: 32] = $urandom;
        rm1[w*32 +: 32] = $urandom;
      end
      cycle(ren, rd0, rd1, rm0, rm1, rdn, rfl);
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
